// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg
//   Shared constants for the mini ALU execute/write-back stage:
//   - INSTR_W: instruction word width (12 bits).
//   - Field layout: [11:9] op, [8:6] rd, [5:3] rs1, [2:0] rs2.
//   - Opcode encodings for the eight register-register operations.
package mini_alu_pkg;

  localparam int unsigned INSTR_W = 12;

  // Every field is three bits wide; each is located by its LSB.
  localparam int unsigned FIELD_W = 3;
  localparam int unsigned OP_LSB  = 9;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned RS1_LSB = 3;
  localparam int unsigned RS2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_ADD  = 3'b000;
  localparam logic [FIELD_W-1:0] OP_SUB  = 3'b001;
  localparam logic [FIELD_W-1:0] OP_AND  = 3'b010;
  localparam logic [FIELD_W-1:0] OP_OR   = 3'b011;
  localparam logic [FIELD_W-1:0] OP_XOR  = 3'b100;
  localparam logic [FIELD_W-1:0] OP_SHL1 = 3'b101;
  localparam logic [FIELD_W-1:0] OP_SHR1 = 3'b110;
  localparam logic [FIELD_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/mini_alu.sv
// mini_alu
//   Purely combinational ALU. All arithmetic wraps modulo 2^WIDTH.
//   Ports:
//     i_op     [2:0]       operation select (encodings in mini_alu_pkg)
//     i_a      [WIDTH-1:0] operand A (rs1)
//     i_b      [WIDTH-1:0] operand B (rs2)
//     o_result [WIDTH-1:0] result
module mini_alu
  import mini_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [FIELD_W-1:0] i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SHL1: o_result = {i_a[WIDTH-2:0], 1'b0};
      OP_SHR1: o_result = {1'b0, i_a[WIDTH-1:1]};
      OP_PASS: o_result = i_a;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/mini_alu_stage.sv
// mini_alu_stage
//   Two-stage execute/write-back pipeline in front of the 8-entry mini
//   register file. Instructions issue into EX on valid&&ready; the ALU
//   result moves to WB one cycle later and WB drives the register file
//   write port. Read-after-write hazards are handled by forwarding when
//   MINI_ALU_FWD_EN is defined, otherwise by holding off issue until the
//   producing instruction has committed.
//   Ports:
//     clk          clock, rising edge
//     rst_n        asynchronous reset, active HIGH
//     instr_valid  instruction presented
//     instr_ready  stage accepts the instruction this cycle (combinational)
//     instr [11:0] {op, rd, rs1, rs2}
//     rf_raddr1/2  register file read addresses (instr rs1 / rs2)
//     rf_rdata1/2  register file asynchronous read data
//     rf_we        register file write enable
//     rf_waddr     register file write address
//     rf_wdata     register file write data
//     zero         WB result is zero (registered with rf_wdata)
//     busy         EX or WB holds a valid instruction
//   Compile-time option: MINI_ALU_FWD_EN selects forwarding over stalling.
module mini_alu_stage
  import mini_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [FIELD_W-1:0] rf_raddr1,
  output logic [FIELD_W-1:0] rf_raddr2,
  input  logic [WIDTH-1:0]   rf_rdata1,
  input  logic [WIDTH-1:0]   rf_rdata2,
  output logic               rf_we,
  output logic [FIELD_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]   rf_wdata,
  output logic               zero,
  output logic               busy
);

  // Instruction field decode
  logic [FIELD_W-1:0] w_op;
  logic [FIELD_W-1:0] w_rd;
  logic [FIELD_W-1:0] w_rs1;
  logic [FIELD_W-1:0] w_rs2;

  assign w_op  = instr[OP_LSB  +: FIELD_W];
  assign w_rd  = instr[RD_LSB  +: FIELD_W];
  assign w_rs1 = instr[RS1_LSB +: FIELD_W];
  assign w_rs2 = instr[RS2_LSB +: FIELD_W];

  assign rf_raddr1 = w_rs1;
  assign rf_raddr2 = w_rs2;

  // EX stage registers
  logic               r_ex_valid;
  logic [FIELD_W-1:0] r_ex_op;
  logic [FIELD_W-1:0] r_ex_rd;
  logic [WIDTH-1:0]   r_ex_a;
  logic [WIDTH-1:0]   r_ex_b;

  // WB stage registers
  logic               r_wb_valid;
  logic [FIELD_W-1:0] r_wb_rd;
  logic [WIDTH-1:0]   r_wb_result;
  logic               r_wb_zero;

  logic [WIDTH-1:0] w_alu_result;
  logic             w_alu_zero;

  mini_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_op     (r_ex_op),
    .i_a      (r_ex_a),
    .i_b      (r_ex_b),
    .o_result (w_alu_result)
  );

  assign w_alu_zero = (w_alu_result == '0);

  // A stage "hits" a source when it will write that register and the
  // write is not yet visible through the register file read ports.
  // rd==0 never hits: r0 is never written.
  logic w_ex_wr;
  logic w_wb_wr;
  logic w_ex_hit1;
  logic w_ex_hit2;
  logic w_wb_hit1;
  logic w_wb_hit2;

  assign w_ex_wr   = r_ex_valid && (r_ex_rd != '0);
  assign w_wb_wr   = r_wb_valid && (r_wb_rd != '0);
  assign w_ex_hit1 = w_ex_wr && (r_ex_rd == w_rs1);
  assign w_ex_hit2 = w_ex_wr && (r_ex_rd == w_rs2);
  assign w_wb_hit1 = w_wb_wr && (r_wb_rd == w_rs1);
  assign w_wb_hit2 = w_wb_wr && (r_wb_rd == w_rs2);

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic             w_stall;

`ifdef MINI_ALU_FWD_EN
  // Youngest producer wins: EX (distance 1) over WB (distance 2).
  always_comb begin
    w_opa = rf_rdata1;
    if (w_ex_hit1) begin
      w_opa = w_alu_result;
    end else if (w_wb_hit1) begin
      w_opa = r_wb_result;
    end
  end

  always_comb begin
    w_opb = rf_rdata2;
    if (w_ex_hit2) begin
      w_opb = w_alu_result;
    end else if (w_wb_hit2) begin
      w_opb = r_wb_result;
    end
  end

  assign w_stall = 1'b0;
`else
  // Without forwarding the reader waits until the producer has left WB,
  // at which point the register file already holds the new value.
  assign w_opa   = rf_rdata1;
  assign w_opb   = rf_rdata2;
  assign w_stall = w_ex_hit1 | w_ex_hit2 | w_wb_hit1 | w_wb_hit2;
`endif

  // rst_n is active high in this codebase
  assign instr_ready = ~rst_n & ~w_stall;

  logic w_issue;
  assign w_issue = instr_valid && instr_ready;

  // Operands are sampled on the issuing edge, so a stalled instruction
  // picks up the committed value once the stall clears.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else begin
      r_ex_valid <= w_issue;
      if (w_issue) begin
        r_ex_op <= w_op;
        r_ex_rd <= w_rd;
        r_ex_a  <= w_opa;
        r_ex_b  <= w_opb;
      end
    end
  end

  // Bubbles advance only the valid bit; WB data keeps its last value.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_result <= '0;
      r_wb_zero   <= 1'b0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_wb_rd     <= r_ex_rd;
        r_wb_result <= w_alu_result;
        r_wb_zero   <= w_alu_zero;
      end
    end
  end

  assign rf_we    = r_wb_valid && (r_wb_rd != '0);
  assign rf_waddr = r_wb_rd;
  assign rf_wdata = r_wb_result;
  assign zero     = r_wb_zero;
  assign busy     = r_ex_valid | r_wb_valid;

endmodule
